// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared FSM encoding and counter sizing for the data-memory responder
// Rev 1.0
// ============================================================================
package dmem_pkg;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_responder_if : CPU data-memory request/ack bundle
// Rev 1.0
// ============================================================================
interface dmem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  busy;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  busy, ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output busy, ack, rdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array : word array with byte-masked synchronous write, async read
// Rev 1.0
// ============================================================================
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NUM_BYTES = DATA_W / 8;

  // Contents are intentionally never reset.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wstrb[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : one-at-a-time load/store responder with LATENCY wait states
// Rev 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  generate
    if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 0..15");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
      $error("dmem_responder: DATA_W must be a multiple of 8");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  accept;

  logic                  cap_we;
  logic [ADDR_W-1:0]     cap_addr;
  logic [DATA_W-1:0]     cap_wdata;
  logic [DATA_W/8-1:0]   cap_wstrb;
  logic [DATA_W-1:0]     rdata_q;

  logic [ADDR_W-1:0]     arr_addr;
  logic [DATA_W-1:0]     arr_rdata;
  logic                  arr_we;
  logic                  is_load;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=0 RESP follows IDLE directly, so the read must use the live address.
  assign arr_addr = (state == IDLE) ? bus.addr : cap_addr;
  assign is_load  = accept ? !bus.we : !cap_we;
  assign arr_we   = (state == RESP) && cap_we && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_we    <= bus.we;
        cap_addr  <= bus.addr;
        cap_wdata <= bus.wdata;
        cap_wstrb <= bus.wstrb;
      end
      if (state_nxt == RESP && state != RESP && is_load) begin
        rdata_q <= arr_rdata;
      end
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (cap_wdata),
    .wstrb (cap_wstrb),
    .rdata (arr_rdata)
  );

  assign bus.busy  = (state != IDLE);
  assign bus.ack   = (state == RESP);
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed bench for LATENCY=2 and LATENCY=0 responders
// Rev 1.0
// ============================================================================
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus2 ();
  dmem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  // One transaction: returns cycles from acceptance edge to the ack cycle (0 = timeout).
  task automatic access(input bit sel0, input bit we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = '0;
    @(negedge clk);
    if (sel0) begin
      bus0.req = 1'b1; bus0.we = we; bus0.addr = a; bus0.wdata = d; bus0.wstrb = s;
    end else begin
      bus2.req = 1'b1; bus2.we = we; bus2.addr = a; bus2.wdata = d; bus2.wstrb = s;
    end
    @(posedge clk);
    #1;
    bus0.req = 1'b0;
    bus2.req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sel0 ? bus0.ack : bus2.ack) begin
        lat = i;
        rd  = sel0 ? bus0.rdata : bus2.rdata;
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (bus2.busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", k, bus2.busy); end
      total++;
      if (bus2.ack !== 1'b0) begin bad++; $display("FAIL reset_ack cyc=%0d got=%b exp=0", k, bus2.ack); end
      total++;
      if (bus2.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata cyc=%0d got=%h exp=0", k, bus2.rdata); end
    end
  endtask

  task automatic test_store_load();
    int lat;
    logic [31:0] rd;
    access(1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, lat, rd);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL store_latency got=%0d exp=3", lat); end
    access(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, lat, rd);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_partial_store();
    int lat;
    logic [31:0] rd;
    access(1'b0, 1'b1, 8'h04, 32'h11223344, 4'b0101, lat, rd);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL partial_latency got=%0d exp=3", lat); end
    access(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL partial_data got=%h exp=de22be44", rd); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int acks;
    logic [31:0] rd;
    logic [7:0]  seq  [3];
    logic [31:0] expv [3];
    seq  = '{8'h04, 8'h08, 8'h04};
    expv = '{32'hDE22BE44, 32'hCAFEF00D, 32'hDE22BE44};
    acks = 0;
    access(1'b0, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, lat, rd);
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      bus2.req = 1'b1;
      bus2.we  = 1'b0;
      // Accepted edges are 1, 5, 9; all others carry a decoy address.
      bus2.addr = (k % 4 == 1) ? seq[(k-1)/4] : 8'h20;
      @(posedge clk);
      @(negedge clk);
      if (bus2.ack === 1'b1) acks++;
      total++;
      if (bus2.ack !== (k % 4 == 3)) begin
        bad++; $display("FAIL b2b_ack cyc=%0d got=%b exp=%b", k, bus2.ack, (k % 4 == 3));
      end
      if (k % 4 == 3) begin
        total++;
        if (bus2.rdata !== expv[(k-3)/4]) begin
          bad++; $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", k, bus2.rdata, expv[(k-3)/4]);
        end
      end
    end
    bus2.req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus2.ack === 1'b1) acks++;
    end
    total++;
    if (acks !== 3) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=3", acks); end
  endtask

  task automatic test_abort();
    int lat;
    int acks;
    logic [31:0] rd;
    acks = 0;
    access(1'b0, 1'b1, 8'h10, 32'h0, 4'hF, lat, rd);
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 8'h10; bus2.wdata = 32'h12345678; bus2.wstrb = 4'hF;
    @(posedge clk);
    #1;
    bus2.req = 1'b0;
    @(negedge clk);
    total++;
    if (bus2.busy !== 1'b1) begin bad++; $display("FAIL abort_in_wait got=%b exp=1", bus2.busy); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus2.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus2.busy); end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus2.ack === 1'b1) acks++;
    end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL abort_ack got=%0d exp=0", acks); end
    access(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL abort_data got=%h exp=0", rd); end
  endtask

  task automatic test_zero_latency();
    int lat;
    logic [31:0] rd;
    access(1'b1, 1'b1, 8'hFF, 32'hAAAA5555, 4'hF, lat, rd);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL l0_store_latency got=%0d exp=1", lat); end
    access(1'b1, 1'b1, 8'h00, 32'h12345678, 4'hF, lat, rd);
    access(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0, lat, rd);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL l0_load_latency got=%0d exp=1", lat); end
    total++;
    if (rd !== 32'hAAAA5555) begin bad++; $display("FAIL l0_data_ff got=%h exp=aaaa5555", rd); end
    access(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h12345678) begin bad++; $display("FAIL l0_data_00 got=%h exp=12345678", rd); end
  endtask

  initial begin
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0; bus2.wstrb = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.wstrb = '0;
    test_reset();
    test_store_load();
    test_partial_store();
    test_back_to_back();
    test_abort();
    test_zero_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
